// File: rtl/rtl_settings_pkg.sv
// ---------------------------------------------------------------------------
// rtl_settings_pkg
//   Shared settings for the memory test datapath: Avalon-MM widths, the
//   locations of the CSR test-parameter fields, and the transaction type
//   encoding used between the control block and the transaction block.
// ---------------------------------------------------------------------------
package rtl_settings_pkg;

  localparam int ADDR_W      = 24;  // word address width
  localparam int AMM_DATA_W  = 32;  // Avalon data width, multiple of 8
  localparam int AMM_BURST_W = 4;   // Avalon burstcount width

  // CSR test parameter register fields
  localparam int BURST_REG_IDX   = 1;  // register holding the burst field
  localparam int BURST_FIELD_LSB = 0;  // burst field occupies AMM_BURST_W-1 bits
  localparam int PATTERN_REG_IDX = 3;  // register holding the pattern byte
  localparam int PATTERN_LSB     = 0;  // pattern byte occupies 8 bits

  typedef enum logic {
    WRITE_TRANS = 1'b0,
    READ_TRANS  = 1'b1
  } trans_type_t;

endpackage

// File: rtl/amm_trans_block.sv
// ---------------------------------------------------------------------------
// amm_trans_block
//   Turns one transaction command (valid/address/type) from the test control
//   block into an Avalon-MM write burst or a single read burst request.
//   Write data is the CSR pattern byte replicated across the data bus.
//   Read data is not consumed here.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_test_i         one-cycle pulse, latches burst length and pattern
//   test_param_reg_i     CSR parameters ([1] burst field, [3] pattern byte)
//   trans_valid_i        command valid; accepted when !in_process_o
//   trans_addr_i         command word address
//   trans_type_i         0 = write, 1 = read
//   in_process_o         a command is being executed
//   busy_o               block busy towards the control block
//   cmd_stb_o            pulse the cycle after the first beat / read request
//   amm_*                Avalon-MM master command interface
// ---------------------------------------------------------------------------
module amm_trans_block
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W      = rtl_settings_pkg::ADDR_W,
  parameter int AMM_DATA_W  = rtl_settings_pkg::AMM_DATA_W,
  parameter int AMM_BURST_W = rtl_settings_pkg::AMM_BURST_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_test_i,
  input  logic [3:1][31:0]        test_param_reg_i,
  input  logic                    trans_valid_i,
  input  logic [ADDR_W-1:0]       trans_addr_i,
  input  logic                    trans_type_i,
  output logic                    in_process_o,
  output logic                    busy_o,
  output logic                    cmd_stb_o,
  output logic [ADDR_W-1:0]       amm_address_o,
  output logic                    amm_read_o,
  output logic                    amm_write_o,
  output logic [AMM_DATA_W-1:0]   amm_writedata_o,
  output logic [AMM_DATA_W/8-1:0] amm_byteenable_o,
  output logic [AMM_BURST_W-1:0]  amm_burstcount_o,
  input  logic                    amm_waitrequest_i
);

  typedef enum logic [1:0] {
    IDLE_S,
    WRITE_S,
    READ_S
  } state_t;

  localparam logic [AMM_BURST_W-1:0] ONE_BEAT = AMM_BURST_W'(1);

  state_t                 state, state_nxt;
  logic [AMM_BURST_W-1:0] burst_len_reg;  // length for the next command
  logic [AMM_BURST_W-1:0] cur_len;        // length of the command in flight
  logic [AMM_BURST_W-1:0] beat_cnt;       // beats still to be accepted
  logic [7:0]             pattern_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic                   first_beat;
  logic                   in_process;
  logic                   accept;
  logic                   beat_done;

  assign accept    = (state == IDLE_S) && trans_valid_i && !in_process;
  assign beat_done = (state != IDLE_S) && !amm_waitrequest_i;

  // NOTE: state is reset asynchronously so the Avalon strobes, which decode
  // directly from it, drop the moment rst_i rises, even mid-burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE_S;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path through it leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt        = state;
    amm_write_o      = 1'b0;
    amm_read_o       = 1'b0;
    amm_address_o    = '0;
    amm_writedata_o  = '0;
    amm_byteenable_o = '0;
    amm_burstcount_o = '0;
    unique case (state)
      IDLE_S: begin
        if (accept)
          state_nxt = (trans_type_t'(trans_type_i) == READ_TRANS) ? READ_S : WRITE_S;
      end
      WRITE_S: begin
        amm_write_o      = 1'b1;
        amm_address_o    = addr_reg;
        amm_writedata_o  = {(AMM_DATA_W/8){pattern_reg}};
        amm_byteenable_o = '1;
        amm_burstcount_o = cur_len;
        if (!amm_waitrequest_i && beat_cnt == ONE_BEAT) state_nxt = IDLE_S;
      end
      READ_S: begin
        amm_read_o       = 1'b1;
        amm_address_o    = addr_reg;
        amm_burstcount_o = cur_len;
        if (!amm_waitrequest_i) state_nxt = IDLE_S;
      end
      default: state_nxt = IDLE_S;
    endcase
  end

  // Datapath. The length of the command in flight is captured in cur_len at
  // acceptance, so a start_test_i reload mid-burst only affects later commands
  // and burstcount never changes within a burst.
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_len_reg <= ONE_BEAT;
      cur_len       <= '0;
      beat_cnt      <= '0;
      pattern_reg   <= '0;
      addr_reg      <= '0;
      first_beat    <= 1'b0;
      in_process    <= 1'b0;
      cmd_stb_o     <= 1'b0;
    end else begin
      cmd_stb_o <= 1'b0;
      if (start_test_i) begin
        // Zero-extend the field before adding one, so the maximum field value
        // yields 2^(AMM_BURST_W-1) without wrapping.
        burst_len_reg <= AMM_BURST_W'(test_param_reg_i[BURST_REG_IDX][BURST_FIELD_LSB +: AMM_BURST_W-1])
                         + ONE_BEAT;
        pattern_reg   <= test_param_reg_i[PATTERN_REG_IDX][PATTERN_LSB +: 8];
      end
      if (accept) begin
        addr_reg   <= trans_addr_i;
        beat_cnt   <= burst_len_reg;
        cur_len    <= burst_len_reg;
        first_beat <= 1'b1;
        in_process <= 1'b1;
      end else if (beat_done) begin
        cmd_stb_o  <= first_beat;
        first_beat <= 1'b0;
        beat_cnt   <= beat_cnt - ONE_BEAT;
        // A read completes on its single request; a write on its last beat.
        if (state == READ_S || beat_cnt == ONE_BEAT) in_process <= 1'b0;
      end
    end
  end

  assign in_process_o = in_process;
  assign busy_o       = in_process || (state != IDLE_S);

endmodule

// File: tb/tb_amm_trans_block.sv
// ---------------------------------------------------------------------------
// tb_amm_trans_block
//   Directed bench for amm_trans_block. Inputs are driven and outputs are
//   sampled on the falling clock edge; every expected value is hand-computed.
// ---------------------------------------------------------------------------
module tb_amm_trans_block;
  import rtl_settings_pkg::*;

  logic                    clk;
  logic                    rst_i;
  logic                    start_test;
  logic [3:1][31:0]        test_param;
  logic                    trans_valid;
  logic [ADDR_W-1:0]       trans_addr;
  logic                    trans_type;
  logic                    in_process;
  logic                    busy;
  logic                    cmd_stb;
  logic [ADDR_W-1:0]       amm_address;
  logic                    amm_read;
  logic                    amm_write;
  logic [AMM_DATA_W-1:0]   amm_writedata;
  logic [AMM_DATA_W/8-1:0] amm_byteenable;
  logic [AMM_BURST_W-1:0]  amm_burstcount;
  logic                    waitreq;

  int vectors    = 0;
  int miscompares = 0;

  // Per-transaction observations filled in by run_txn
  int n_strobe, n_beats, n_hi, n_stb, stb_at;

  amm_trans_block dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_test_i      (start_test),
    .test_param_reg_i  (test_param),
    .trans_valid_i     (trans_valid),
    .trans_addr_i      (trans_addr),
    .trans_type_i      (trans_type),
    .in_process_o      (in_process),
    .busy_o            (busy),
    .cmd_stb_o         (cmd_stb),
    .amm_address_o     (amm_address),
    .amm_read_o        (amm_read),
    .amm_write_o       (amm_write),
    .amm_writedata_o   (amm_writedata),
    .amm_byteenable_o  (amm_byteenable),
    .amm_burstcount_o  (amm_burstcount),
    .amm_waitrequest_i (waitreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_params(input logic [31:0] burst_field, input logic [7:0] pat);
    @(negedge clk);
    test_param[1] = burst_field;
    test_param[3] = {24'h0, pat};
    start_test    = 1'b1;
    @(negedge clk);
    start_test    = 1'b0;
  endtask

  // Presents one command, then watches 16 cycles. wseq[c] is the waitrequest
  // value in observation cycle c (cycle 0 = first cycle after acceptance).
  // Every strobed cycle is checked for address, burstcount, data, byteenable.
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic typ,
                         input logic [AMM_BURST_W-1:0] exp_bc, input logic [7:0] pat,
                         input logic [15:0] wseq, input bit mid_start,
                         input logic [31:0] new_field);
    @(negedge clk);
    trans_valid = 1'b1;
    trans_addr  = addr;
    trans_type  = typ;
    waitreq     = 1'b0;
    @(negedge clk);
    trans_valid = 1'b0;
    n_strobe = 0; n_beats = 0; n_hi = 0; n_stb = 0; stb_at = -1;
    for (int c = 0; c < 16; c++) begin
      waitreq = wseq[c];
      if (mid_start && c == 1) begin
        test_param[1] = new_field;
        start_test    = 1'b1;
      end else begin
        start_test    = 1'b0;
      end
      if (amm_write || amm_read) begin
        n_strobe++;
        if (!waitreq) n_beats++;
        check("strobe_type", {amm_write, amm_read}, typ ? 2'b01 : 2'b10);
        check("address", 64'(amm_address), 64'(addr));
        check("burstcount", 64'(amm_burstcount), 64'(exp_bc));
        if (!typ) begin
          check("writedata", 64'(amm_writedata), 64'({4{pat}}));
          check("byteenable", 64'(amm_byteenable), 64'hF);
        end
      end
      if (in_process) n_hi++;
      if (cmd_stb) begin
        n_stb++;
        stb_at = c;
      end
      @(negedge clk);
    end
    waitreq    = 1'b0;
    start_test = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    start_test  = 1'b0;
    test_param  = '0;
    trans_valid = 1'b0;
    trans_addr  = '0;
    trans_type  = 1'b0;
    waitreq     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_process", in_process, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_stb", cmd_stb, 1'b0);
    check("rst_read", amm_read, 1'b0);
    check("rst_write", amm_write, 1'b0);
    check("rst_address", 64'(amm_address), 64'h0);
    rst_i = 1'b0;

    // 1: field 3 -> 4-beat write of 0xA5A5A5A5 at 0x10, no stalls.
    // in_process is high for the 4 beat cycles; with the acceptance cycle the
    // command spans 5 cycles.
    set_params(32'd3, 8'hA5);
    run_txn(24'h10, 1'b0, 4'd4, 8'hA5, 16'h0000, 1'b0, 32'd0);
    check("t1_strobe_cycles", n_strobe, 4);
    check("t1_beats", n_beats, 4);
    check("t1_in_process_cycles", n_hi, 4);
    check("t1_cmd_stb_count", n_stb, 1);
    check("t1_cmd_stb_cycle", 64'(stb_at), 64'd1);

    // 2: field 7 -> read at 0x20, burstcount 8, waitrequest high 3 cycles
    set_params(32'd7, 8'hA5);
    run_txn(24'h20, 1'b1, 4'd8, 8'hA5, 16'b0111, 1'b0, 32'd0);
    check("t2_read_cycles", n_strobe, 4);
    check("t2_accepted", n_beats, 1);
    check("t2_in_process_cycles", n_hi, 4);
    check("t2_cmd_stb_cycle", 64'(stb_at), 64'd4);

    // 3: field 1 -> 2-beat write, waitrequest 1,0,1,1,0
    set_params(32'd1, 8'h3C);
    run_txn(24'h33, 1'b0, 4'd2, 8'h3C, 16'b01101, 1'b0, 32'd0);
    check("t3_write_cycles", n_strobe, 5);
    check("t3_beats", n_beats, 2);
    check("t3_in_process_cycles", n_hi, 5);
    check("t3_cmd_stb_cycle", 64'(stb_at), 64'd2);

    // 4: back-to-back 2-beat write then read with trans_valid held high
    @(negedge clk);
    trans_valid = 1'b1;
    trans_type  = 1'b0;
    trans_addr  = 24'h40;
    @(negedge clk);                       // beat 1
    check("t4_wr_in_process", in_process, 1'b1);
    check("t4_wr_write", amm_write, 1'b1);
    trans_type  = 1'b1;                   // next command, ignored while busy
    trans_addr  = 24'h50;
    @(negedge clk);                       // beat 2
    check("t4_wr_addr_held", 64'(amm_address), 64'h40);
    @(negedge clk);                       // the single idle cycle
    check("t4_gap_in_process", in_process, 1'b0);
    check("t4_gap_busy", busy, 1'b0);
    check("t4_gap_write", amm_write, 1'b0);
    @(negedge clk);
    check("t4_rd_read", amm_read, 1'b1);
    check("t4_rd_address", 64'(amm_address), 64'h50);
    check("t4_rd_burstcount", 64'(amm_burstcount), 64'd2);
    check("t4_rd_in_process", in_process, 1'b1);
    trans_valid = 1'b0;
    @(negedge clk);
    check("t4_done_read", amm_read, 1'b0);
    check("t4_done_in_process", in_process, 1'b0);

    // 5: reset during beat 2 of a 4-beat write
    set_params(32'd3, 8'h5A);
    @(negedge clk);
    trans_valid = 1'b1;
    trans_type  = 1'b0;
    trans_addr  = 24'h60;
    @(negedge clk);                       // beat 1
    trans_valid = 1'b0;
    check("t5_beat1_write", amm_write, 1'b1);
    @(negedge clk);                       // beat 2
    rst_i = 1'b1;
    #1;
    check("t5_rst_write", amm_write, 1'b0);
    check("t5_rst_in_process", in_process, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_cmd_stb", cmd_stb, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;

    // 6: after reset, 4-beat write with start_test (field 0) mid-burst;
    // the burst keeps 4 beats, the next write issues a single beat.
    set_params(32'd3, 8'h5A);
    run_txn(24'h70, 1'b0, 4'd4, 8'h5A, 16'h0000, 1'b1, 32'd0);
    check("t6_strobe_cycles", n_strobe, 4);
    check("t6_beats", n_beats, 4);
    check("t6_cmd_stb_cycle", 64'(stb_at), 64'd1);
    run_txn(24'h74, 1'b0, 4'd1, 8'h5A, 16'h0000, 1'b0, 32'd0);
    check("t6_next_beats", n_beats, 1);
    check("t6_next_in_process_cycles", n_hi, 1);
    check("t6_next_cmd_stb_count", n_stb, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
